toggle_event_rx: RTL and testbench
==================================

TOGGLE_EVENT_RX -- requirements
Module: toggle_event_rx

Interface
REQ-001 SHALL have parameter CNT_W, default 4, which is the width of the pending-event counter.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: reset is synchronous and active-low (reset==0 resets on a rising clk edge).
REQ-004 SHALL have port t_in, input, 1 bit: toggle-encoded event line from a T-flip-flop transmitter, asynchronous to clk; each level change is one event.
REQ-005 SHALL have port clr_ovf, input, 1 bit: synchronous clear of the overflow flag.
REQ-006 SHALL have port ev_ready, input, 1 bit: consumer accepts one pending event.
REQ-007 SHALL have port ev_pulse, output, 1 bit: one-cycle strobe per detected toggle.
REQ-008 SHALL have port ev_valid, output, 1 bit: high whenever pending != 0.
REQ-009 SHALL have port pending, output, CNT_W bits: count of events not yet accepted.
REQ-010 SHALL have port overflow, output, 1 bit: sticky flag set when an event is lost.
REQ-011 SHALL have port q, output, 1 bit: the tracked (synchronized) level of t_in.
REQ-012 SHALL have port qbar, output, 1 bit: always ~q.

Function
REQ-013 SHALL synchronize t_in through two flops (s1, s2) and hold the last seen level in register q.
REQ-014 SHALL detect an event when s2 != q outside reset; on that edge q <= s2 and ev_pulse <= 1, otherwise ev_pulse <= 0.
REQ-015 SHALL apply fixed latency: a t_in change that meets setup before edge k produces ev_pulse high in the cycle after edge k+2, for exactly one cycle.
REQ-016 SHALL treat an accept as ev_valid && ev_ready, sampled on the rising edge.
REQ-017 SHALL update pending, on the same edge that raises ev_pulse: event only -> +1; accept only -> -1; event and accept together -> unchanged; neither -> unchanged.
REQ-018 SHALL handle the full case, event without accept while pending == 2^CNT_W-1: pending holds, the event is dropped, and overflow <= 1.
REQ-019 SHALL NOT set overflow when an event and an accept coincide at full.
REQ-020 SHALL ignore ev_ready when pending == 0: no underflow, pending stays 0.
REQ-021 SHALL keep overflow high until clr_ovf==1 or reset; if clr_ovf and a new overflow occur on the same edge, overflow SHALL read 1 (set wins).
REQ-022 SHALL limit t_in toggles to at most one per 3 clk cycles; faster toggling gives undefined counts (this is the documented constraint, not checked).
REQ-023 SHALL drive ev_valid combinationally from pending != 0 and qbar as ~q; all other outputs SHALL be registered.

Reset
REQ-024 SHALL, while reset==0: s1 <= t_in, s2 <= s1, q <= s2, ev_pulse=0, pending=0, overflow=0; no event detection.
REQ-025 SHALL require reset to be held for at least 3 cycles with t_in stable, so that q equals t_in at release and the level present at release is NOT an event.
REQ-026 SHALL, when reset is asserted mid-operation, discard all pending events and any toggle in the synchronizer pipeline.

Structure
REQ-027 SHALL place the default CNT_W and the sync-depth constant (2) in a shared package, toggle_pkg.
REQ-028 SHALL factor the synchronizer into one sub-module, sync2ff (d, clk, reset -> q); the counter and detector stay inline.

Verification
REQ-029 SHALL cover single toggle: reset 3 cycles with t_in=0, then t_in 0->1 before edge 10 -> ev_pulse high in the cycle after edge 12 only, pending=1, q=1, qbar=0.
REQ-030 SHALL cover a burst with no consumer: 5 toggles spaced 4 cycles apart, ev_ready=0 -> pending=5, ev_valid=1, overflow=0.
REQ-031 SHALL cover saturation (CNT_W=4): 16 toggles with ev_ready=0 -> pending=15, overflow=1; then clr_ovf pulse -> overflow=0, pending=15.
REQ-032 SHALL cover simultaneous event and accept: pending=3, ev_ready=1 on the edge of a new event -> pending stays 3; at pending=15 the same case -> overflow stays 0.
REQ-033 SHALL cover drain and underflow: pending=2, ev_ready held 4 cycles -> pending 1, 0, 0, 0; ev_valid falls after the second accept.
REQ-034 SHALL cover reset mid-stream: pending=4 with a toggle 1 cycle into the synchronizer, reset low 3 cycles -> pending=0, no ev_pulse after release, q equals t_in.

Source files
------------

// File: rtl/toggle_pkg.sv
// Shared constants and pending-counter update helper for the toggle event receiver.
package toggle_pkg;

    localparam int CNT_W_DEF  = 4;
    localparam int SYNC_DEPTH = 2;

    typedef enum logic [1:0] {
        PEND_HOLD = 2'd0,
        PEND_INC  = 2'd1,
        PEND_DEC  = 2'd2,
        PEND_DROP = 2'd3
    } pend_op_e;

    // An event arriving at a full counter with no accept is lost; event plus accept nets to zero.
    function automatic pend_op_e pend_op(input logic det, input logic acc, input logic full);
        pend_op_e op;
        if (det && !acc) begin
            if (full) begin
                op = PEND_DROP;
            end else begin
                op = PEND_INC;
            end
        end else if (!det && acc) begin
            op = PEND_DEC;
        end else begin
            op = PEND_HOLD;
        end
        return op;
    endfunction

endpackage

// File: rtl/sync2ff.sv
// Two-flop synchronizer for the asynchronous toggle line.
module sync2ff
    import toggle_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [SYNC_DEPTH-1:0] pipe_q;

    // The pipe keeps shifting during reset so it flushes to the live input level.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pipe_q <= {pipe_q[SYNC_DEPTH-2:0], d};
        end else begin
            pipe_q <= {pipe_q[SYNC_DEPTH-2:0], d};
        end
    end

    assign q = pipe_q[SYNC_DEPTH-1];

endmodule

// File: rtl/toggle_event_rx.sv
// Receives toggle-encoded events, strobes each one and keeps a saturating count
// of events awaiting acceptance with a sticky loss flag.
module toggle_event_rx
    import toggle_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             t_in,
    input  logic             clr_ovf,
    input  logic             ev_ready,
    output logic             ev_pulse,
    output logic             ev_valid,
    output logic [CNT_W-1:0] pending,
    output logic             overflow,
    output logic             q,
    output logic             qbar
);

    logic             s2_s;
    logic             det_s;
    logic             acc_s;
    logic             full_s;
    pend_op_e         op_s;
    logic             q_q;
    logic             ev_pulse_q;
    logic [CNT_W-1:0] pending_q;
    logic [CNT_W-1:0] pending_d;
    logic             overflow_q;
    logic             overflow_d;

    sync2ff u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (t_in),
        .q     (s2_s)
    );

    assign det_s  = (s2_s != q_q);
    assign acc_s  = ev_valid && ev_ready;
    assign full_s = (pending_q == {CNT_W{1'b1}});

    // Next-state for the pending counter and the sticky overflow flag (set beats clear).
    always_comb begin
        op_s       = pend_op(det_s, acc_s, full_s);
        pending_d  = pending_q;
        overflow_d = overflow_q;
        case (op_s)
            PEND_INC:  pending_d = pending_q + CNT_W'(1);
            PEND_DEC:  pending_d = pending_q - CNT_W'(1);
            PEND_DROP: pending_d = pending_q;
            PEND_HOLD: pending_d = pending_q;
            default:   pending_d = pending_q;
        endcase
        if (op_s == PEND_DROP) begin
            overflow_d = 1'b1;
        end else if (clr_ovf) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
    end

    // Level tracker, event strobe and counter state; q follows s2 even in reset so
    // the level present at release is never reported as an event.
    always_ff @(posedge clk) begin
        if (!reset) begin
            q_q        <= s2_s;
            ev_pulse_q <= 1'b0;
            pending_q  <= {CNT_W{1'b0}};
            overflow_q <= 1'b0;
        end else begin
            q_q        <= s2_s;
            ev_pulse_q <= det_s;
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
        end
    end

    assign ev_pulse = ev_pulse_q;
    assign pending  = pending_q;
    assign overflow = overflow_q;
    assign ev_valid = (pending_q != {CNT_W{1'b0}});
    assign q        = q_q;
    assign qbar     = ~q_q;

endmodule

// File: tb/tb_toggle_event_rx.sv
// Directed self-checking bench for toggle_event_rx with CNT_W=4.
module tb_toggle_event_rx;

    logic       clk = 1'b0;
    logic       reset;
    logic       t_in;
    logic       clr_ovf;
    logic       ev_ready;
    logic       ev_pulse;
    logic       ev_valid;
    logic [3:0] pending;
    logic       overflow;
    logic       q;
    logic       qbar;

    int err_cnt = 0;
    int chk_cnt = 0;

    toggle_event_rx #(.CNT_W(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .t_in     (t_in),
        .clr_ovf  (clr_ovf),
        .ev_ready (ev_ready),
        .ev_pulse (ev_pulse),
        .ev_valid (ev_valid),
        .pending  (pending),
        .overflow (overflow),
        .q        (q),
        .qbar     (qbar)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge: flip t_in, optionally assert ev_ready/clr_ovf on the detection edge,
    // and verify the strobe appears exactly three edges later for one cycle.
    task automatic send_toggle(input logic accept, input logic clr);
        t_in = ~t_in;
        cycles(1);
        check_val("pulse_lat1", {31'd0, ev_pulse}, 32'd0);
        cycles(1);
        check_val("pulse_lat2", {31'd0, ev_pulse}, 32'd0);
        ev_ready = accept;
        clr_ovf  = clr;
        cycles(1);
        ev_ready = 1'b0;
        clr_ovf  = 1'b0;
        check_val("pulse_hi", {31'd0, ev_pulse}, 32'd1);
        check_val("q_track", {31'd0, q}, {31'd0, t_in});
        cycles(1);
        check_val("pulse_lo", {31'd0, ev_pulse}, 32'd0);
    endtask

    initial begin
        logic [3:0] drain_exp [4];
        logic       valid_exp [4];
        drain_exp = '{4'd1, 4'd0, 4'd0, 4'd0};
        valid_exp = '{1'b1, 1'b0, 1'b0, 1'b0};

        reset    = 1'b0;
        t_in     = 1'b0;
        clr_ovf  = 1'b0;
        ev_ready = 1'b0;
        cycles(4);
        check_val("rst_pending", {28'd0, pending}, 32'd0);
        check_val("rst_overflow", {31'd0, overflow}, 32'd0);
        check_val("rst_pulse", {31'd0, ev_pulse}, 32'd0);
        check_val("rst_valid", {31'd0, ev_valid}, 32'd0);
        check_val("rst_q", {31'd0, q}, 32'd0);
        check_val("rst_qbar", {31'd0, qbar}, 32'd1);
        reset = 1'b1;
        cycles(3);
        check_val("release_pulse", {31'd0, ev_pulse}, 32'd0);
        check_val("release_pending", {28'd0, pending}, 32'd0);

        // Single toggle.
        send_toggle(1'b0, 1'b0);
        check_val("single_pending", {28'd0, pending}, 32'd1);
        check_val("single_q", {31'd0, q}, 32'd1);
        check_val("single_qbar", {31'd0, qbar}, 32'd0);
        check_val("single_valid", {31'd0, ev_valid}, 32'd1);

        // Burst with no consumer, up to five events.
        for (int i = 0; i < 4; i++) send_toggle(1'b0, 1'b0);
        check_val("burst_pending", {28'd0, pending}, 32'd5);
        check_val("burst_valid", {31'd0, ev_valid}, 32'd1);
        check_val("burst_overflow", {31'd0, overflow}, 32'd0);

        // Fill to full, then one more event is dropped.
        for (int i = 0; i < 10; i++) send_toggle(1'b0, 1'b0);
        check_val("full_pending", {28'd0, pending}, 32'd15);
        check_val("full_no_ovf", {31'd0, overflow}, 32'd0);
        send_toggle(1'b0, 1'b0);
        check_val("sat_pending", {28'd0, pending}, 32'd15);
        check_val("sat_overflow", {31'd0, overflow}, 32'd1);
        clr_ovf = 1'b1;
        cycles(1);
        clr_ovf = 1'b0;
        check_val("clr_overflow", {31'd0, overflow}, 32'd0);
        check_val("clr_pending", {28'd0, pending}, 32'd15);

        // Event and accept together at full: no loss.
        send_toggle(1'b1, 1'b0);
        check_val("full_ev_acc_pending", {28'd0, pending}, 32'd15);
        check_val("full_ev_acc_ovf", {31'd0, overflow}, 32'd0);

        // Loss coinciding with clr_ovf: set wins.
        send_toggle(1'b0, 1'b1);
        check_val("set_wins_ovf", {31'd0, overflow}, 32'd1);
        check_val("set_wins_pending", {28'd0, pending}, 32'd15);
        clr_ovf = 1'b1;
        cycles(1);
        clr_ovf = 1'b0;
        check_val("clr2_overflow", {31'd0, overflow}, 32'd0);

        // Drain to 3, then event plus accept holds.
        ev_ready = 1'b1;
        cycles(12);
        ev_ready = 1'b0;
        check_val("drain_to3", {28'd0, pending}, 32'd3);
        send_toggle(1'b1, 1'b0);
        check_val("ev_acc_pending3", {28'd0, pending}, 32'd3);

        // Drain from 2 with ready held: no underflow.
        ev_ready = 1'b1;
        cycles(1);
        ev_ready = 1'b0;
        check_val("drain_to2", {28'd0, pending}, 32'd2);
        ev_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycles(1);
            check_val("drain_pending", {28'd0, pending}, {28'd0, drain_exp[i]});
            check_val("drain_valid", {31'd0, ev_valid}, {31'd0, valid_exp[i]});
        end
        ev_ready = 1'b0;

        // Reset mid-stream with a toggle one stage into the synchronizer.
        for (int i = 0; i < 4; i++) send_toggle(1'b0, 1'b0);
        check_val("pre_rst_pending", {28'd0, pending}, 32'd4);
        t_in = ~t_in;
        cycles(1);
        reset = 1'b0;
        cycles(3);
        check_val("mid_rst_pending", {28'd0, pending}, 32'd0);
        check_val("mid_rst_pulse", {31'd0, ev_pulse}, 32'd0);
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cycles(1);
            check_val("post_rst_pulse", {31'd0, ev_pulse}, 32'd0);
            check_val("post_rst_pending", {28'd0, pending}, 32'd0);
        end
        check_val("post_rst_q", {31'd0, q}, {31'd0, t_in});
        check_val("post_rst_qbar", {31'd0, qbar}, {31'd0, ~t_in});

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
